// File: rtl/pll_lock_supervisor.sv
// Supervises a PLL: drives its reset, qualifies lock, retries on timeout and
// releases NUM_DOM downstream resets in order once lock is trusted.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_PLL_RST   | PLL held in reset for PLL_RST_CYCLES cycles
// S_WAIT_LOCK | PLL running, waiting for synchronised lock
// S_FILTER    | counting consecutive lock-high cycles
// S_RELEASE   | releasing domain resets one every STAGE_GAP cycles
// S_RUN       | all domains released, watching for lock loss
// S_FAULT     | retries exhausted, PLL held in reset until restart
module pll_lock_supervisor #(
    parameter int NUM_DOM        = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_FILT      = 64,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STAGE_GAP      = 8,
    parameter int MAX_RETRY      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock_i,
    input  logic               restart_i,
    output logic               pll_rst_o,
    output logic [NUM_DOM-1:0] dom_rst_n_o,
    output logic               ready_o,
    output logic               fault_o,
    output logic               lock_loss_o,
    output logic [7:0]         retry_cnt_o
);

    localparam int RST_W = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
    localparam int TMR_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int FLT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    localparam logic [RST_W-1:0] RST_LAST    = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [FLT_W-1:0] FLT_LAST    = FLT_W'(LOCK_FILT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(STAGE_GAP - 1);
    localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRY);

    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_FILTER    = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    logic [2:0]         state;
    logic [RST_W-1:0]   rst_cnt;
    logic [TMR_W-1:0]   timer;
    logic [FLT_W-1:0]   filt_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               lock_meta;
    logic               lock_s;
    logic [NUM_DOM-1:0] dom_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock_i;
            lock_s    <= lock_meta;
        end
    end

    // Domains come out of reset LSB first by shifting a one in from the bottom.
    always_comb begin
        dom_next = (dom_rst_n_o << 1) | NUM_DOM'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_PLL_RST;
            rst_cnt     <= '0;
            timer       <= '0;
            filt_cnt    <= '0;
            gap_cnt     <= '0;
            pll_rst_o   <= 1'b1;
            dom_rst_n_o <= '0;
            ready_o     <= 1'b0;
            fault_o     <= 1'b0;
            lock_loss_o <= 1'b0;
            retry_cnt_o <= '0;
        end else begin
            lock_loss_o <= 1'b0;
            if (restart_i) begin
                state       <= S_PLL_RST;
                rst_cnt     <= '0;
                retry_cnt_o <= '0;
                fault_o     <= 1'b0;
                dom_rst_n_o <= '0;
                ready_o     <= 1'b0;
                pll_rst_o   <= 1'b1;
            end else begin
                case (state)
                    S_PLL_RST: begin
                        if (rst_cnt == RST_LAST) begin
                            state     <= S_WAIT_LOCK;
                            pll_rst_o <= 1'b0;
                            timer     <= '0;
                        end else begin
                            rst_cnt <= rst_cnt + 1'b1;
                        end
                    end
                    // The attempt timer spans both states so lock glitches cannot extend it.
                    S_WAIT_LOCK, S_FILTER: begin
                        if (timer == TMR_LAST) begin
                            pll_rst_o <= 1'b1;
                            if (MAX_RETRY != 0 && retry_cnt_o == RETRY_LIMIT) begin
                                state   <= S_FAULT;
                                fault_o <= 1'b1;
                            end else begin
                                state   <= S_PLL_RST;
                                rst_cnt <= '0;
                                if (retry_cnt_o != 8'hFF) begin
                                    retry_cnt_o <= retry_cnt_o + 8'd1;
                                end
                            end
                        end else begin
                            timer <= timer + 1'b1;
                            if (state == S_WAIT_LOCK) begin
                                if (lock_s) begin
                                    state    <= S_FILTER;
                                    filt_cnt <= '0;
                                end
                            end else if (!lock_s) begin
                                state    <= S_WAIT_LOCK;
                                filt_cnt <= '0;
                            end else if (filt_cnt == FLT_LAST) begin
                                state   <= S_RELEASE;
                                gap_cnt <= '0;
                            end else begin
                                filt_cnt <= filt_cnt + 1'b1;
                            end
                        end
                    end
                    S_RELEASE, S_RUN: begin
                        if (!lock_s) begin
                            state       <= S_PLL_RST;
                            rst_cnt     <= '0;
                            pll_rst_o   <= 1'b1;
                            dom_rst_n_o <= '0;
                            ready_o     <= 1'b0;
                            lock_loss_o <= 1'b1;
                            retry_cnt_o <= '0;
                        end else if (state == S_RELEASE) begin
                            if (gap_cnt == GAP_LAST) begin
                                gap_cnt     <= '0;
                                dom_rst_n_o <= dom_next;
                                if (&dom_next) begin
                                    ready_o <= 1'b1;
                                    state   <= S_RUN;
                                end
                            end else begin
                                gap_cnt <= gap_cnt + 1'b1;
                            end
                        end
                    end
                    S_FAULT: begin
                        pll_rst_o   <= 1'b1;
                        dom_rst_n_o <= '0;
                        ready_o     <= 1'b0;
                    end
                    default: begin
                        state       <= S_PLL_RST;
                        rst_cnt     <= '0;
                        pll_rst_o   <= 1'b1;
                        dom_rst_n_o <= '0;
                        ready_o     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a time-based reference model queues
// the expected outputs every edge and a negedge monitor compares them.
module tb_pll_lock_supervisor;

    localparam int N_DOM = 3;
    localparam int PR    = 4;
    localparam int LF    = 4;
    localparam int TO    = 32;
    localparam int SG    = 2;
    localparam int MR    = 2;

    localparam int P_PRST = 0, P_LOCKING = 1, P_RELEASE = 2, P_RUN = 3, P_FAULT = 4;
    localparam logic [14:0] RESET_V = {1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pll_lock_i;
    logic             restart_i;
    logic             pll_rst_o;
    logic [N_DOM-1:0] dom_rst_n_o;
    logic             ready_o;
    logic             fault_o;
    logic             lock_loss_o;
    logic [7:0]       retry_cnt_o;
    logic [14:0]      act;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        int          phase;
        logic [14:0] v;
    } exp_t;
    exp_t sb_q[$];

    pll_lock_supervisor #(
        .NUM_DOM(N_DOM), .PLL_RST_CYCLES(PR), .LOCK_FILT(LF),
        .LOCK_TIMEOUT(TO), .STAGE_GAP(SG), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock_i(pll_lock_i), .restart_i(restart_i),
        .pll_rst_o(pll_rst_o), .dom_rst_n_o(dom_rst_n_o), .ready_o(ready_o),
        .fault_o(fault_o), .lock_loss_o(lock_loss_o), .retry_cnt_o(retry_cnt_o)
    );

    always #5 clk = ~clk;

    assign act = {pll_rst_o, dom_rst_n_o, ready_o, fault_o, lock_loss_o, retry_cnt_o};

    // Reference model: phases with entry times; outputs follow from elapsed cycles.
    int m_cyc, m_phase, m_ph_start, m_att_start, m_rel_start, m_high, m_retry;
    bit m_s1, m_s2, m_loss;

    always @(posedge clk) begin
        bit          ls;
        int          released;
        exp_t        e;
        if (!rst_n) begin
            m_cyc = 0; m_phase = P_PRST; m_ph_start = 0; m_retry = 0;
            m_s1 = 1'b0; m_s2 = 1'b0; m_high = 0;
        end else begin
            m_cyc++;
            ls = m_s2; m_s2 = m_s1; m_s1 = pll_lock_i;
            m_loss = 1'b0;
            if (restart_i) begin
                m_phase = P_PRST; m_ph_start = m_cyc; m_retry = 0;
            end else begin
                case (m_phase)
                    P_PRST: if (m_cyc - m_ph_start == PR) begin
                        m_phase = P_LOCKING; m_att_start = m_cyc; m_high = 0;
                    end
                    P_LOCKING: begin
                        if (m_cyc - m_att_start == TO) begin
                            if (MR != 0 && m_retry == MR) m_phase = P_FAULT;
                            else begin
                                m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                                m_phase = P_PRST; m_ph_start = m_cyc;
                            end
                        end else begin
                            m_high = ls ? m_high + 1 : 0;
                            // first high sample moves to filtering, LF more release
                            if (m_high == LF + 1) begin
                                m_phase = P_RELEASE; m_rel_start = m_cyc;
                            end
                        end
                    end
                    P_RELEASE, P_RUN: begin
                        if (!ls) begin
                            m_phase = P_PRST; m_ph_start = m_cyc; m_retry = 0; m_loss = 1'b1;
                        end else if (m_phase == P_RELEASE && (m_cyc - m_rel_start) / SG >= N_DOM)
                            m_phase = P_RUN;
                    end
                    default: ;
                endcase
            end
            released = (m_phase == P_RUN) ? N_DOM :
                       (m_phase == P_RELEASE) ? (m_cyc - m_rel_start) / SG : 0;
            e.cyc   = m_cyc;
            e.phase = m_phase;
            e.v     = {(m_phase == P_PRST || m_phase == P_FAULT), N_DOM'((1 << released) - 1),
                       (m_phase == P_RUN), (m_phase == P_FAULT), m_loss, 8'(m_retry)};
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            n_chk++;
            if (act !== RESET_V) begin
                n_fail++;
                $display("FAIL reset_hold: got %b want %b", act, RESET_V);
            end
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_chk++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL outputs cycle %0d phase %0d: got pll_rst=%b dom=%b ready=%b fault=%b loss=%b retry=%0d, want pll_rst=%b dom=%b ready=%b fault=%b loss=%b retry=%0d",
                         e.cyc, e.phase, act[14], act[13:11], act[10], act[9], act[8], act[7:0],
                         e.v[14], e.v[13:11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_restart();
        restart_i = 1'b1;
        cyc(1);
        restart_i = 1'b0;
    endtask

    task automatic wait_dom0(input int budget);
        int k;
        k = 0;
        while (dom_rst_n_o[0] !== 1'b1 && k < budget) begin
            cyc(1);
            k++;
        end
        n_chk++;
        if (dom_rst_n_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL dom0_release_wait: dom_rst_n_o=%b after %0d cycles, want bit0=1", dom_rst_n_o, budget);
        end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        pll_lock_i = 1'b0;
        restart_i  = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // normal bring-up
        cyc(3 + $urandom_range(8, 12));
        pll_lock_i = 1'b1;
        cyc(30);

        // lock loss in RUN followed by a glitchy relock
        pll_lock_i = 1'b0;
        cyc(12);
        pll_lock_i = 1'b1; cyc(3);
        pll_lock_i = 1'b0; cyc(2);
        pll_lock_i = 1'b1; cyc(30);

        // short random drops, some landing during RELEASE
        for (int i = 0; i < 4; i++) begin
            pll_lock_i = 1'b0;
            cyc($urandom_range(1, 4));
            pll_lock_i = 1'b1;
            cyc($urandom_range(12, 30));
        end
        cyc(20);

        // glitch placed randomly inside the attempt window, sometimes past timeout
        pll_lock_i = 1'b0;
        pulse_restart();
        cyc(4 + $urandom_range(10, 28));
        pll_lock_i = 1'b1; cyc(3);
        pll_lock_i = 1'b0; cyc(2);
        pll_lock_i = 1'b1; cyc(60);

        // no lock: retries then fault
        pll_lock_i = 1'b0;
        pulse_restart();
        cyc(3 * (PR + TO) + 40);

        // restart out of FAULT
        pulse_restart();
        cyc($urandom_range(5, 15));
        pll_lock_i = 1'b1;
        cyc(30);

        // restart coincident with lock-loss detection in RUN
        pll_lock_i = 1'b0;
        cyc(2);
        pulse_restart();
        cyc($urandom_range(3, 8));
        pll_lock_i = 1'b1;
        cyc(30);

        // async reset during RELEASE
        pll_lock_i = 1'b0;
        cyc(6);
        pll_lock_i = 1'b1;
        wait_dom0(60);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (act !== RESET_V) begin
            n_fail++;
            $display("FAIL async_reset: got %b want %b", act, RESET_V);
        end
        cyc(2);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Supervises a vendor PLL instance and turns its raw lock output into staged, lock-qualified reset releases for NUM_DOM downstream domains (PWM, ADC capture, FOC math, comms).
- Drives the PLL reset, filters lock glitches, retries on lock timeout, and latches a fault after MAX_RETRY failed attempts.
- Re-sequences the whole clock tree on lock loss.
- Runs on the free-running board oscillator, the same clock that feeds the PLL input.

Parameters:
NUM_DOM, 4, number of reset domains released in order, 1..16
PLL_RST_CYCLES, 16, cycles pll_rst_o is held high per attempt, >=1
LOCK_FILT, 64, consecutive synchronised-lock-high cycles needed before release, >=1
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK+FILTER per attempt, >LOCK_FILT
STAGE_GAP, 8, cycles between successive domain releases, >=1
MAX_RETRY, 3, timeouts tolerated before FAULT; 0 = retry forever

Ports:
clk  input  1  free-running oscillator clock; same net that drives PLL input
rst_n  input  1  asynchronous active-low reset
pll_lock_i  input  1  raw PLL lock, asynchronous to clk
restart_i  input  1  single-cycle request to restart the full sequence
pll_rst_o  output  1  PLL reset, active high
dom_rst_n_o  output  NUM_DOM  per-domain active-low reset; bit 0 released first
ready_o  output  1  high while all domains are released and lock is good
fault_o  output  1  sticky lock-failure flag
lock_loss_o  output  1  one-cycle pulse when lock drops during RELEASE or RUN
retry_cnt_o  output  8  timeouts in the current bring-up, saturating at 255

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = PLL_RST, all counters 0.
  - Outputs: pll_rst_o=1, dom_rst_n_o=0, ready_o=0, fault_o=0, lock_loss_o=0, retry_cnt_o=0.
- pll_lock_i passes through a 2-FF synchroniser (lock_s). The FSM acts on lock_s at the next edge, so any pin change has a 3-edge response.
- All outputs are registered. Counter widths are $clog2 of their maximum value.
- States:
  - PLL_RST: pll_rst_o=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK with the timeout timer cleared.
  - WAIT_LOCK: pll_rst_o=0; timer increments each cycle. lock_s=1 -> FILTER with filter count 0.
  - FILTER: filter count increments while lock_s=1. lock_s=0 -> back to WAIT_LOCK; filter count clears, timer does not. Count reaching LOCK_FILT -> RELEASE with gap counter cleared.
  - Timeout: timer reaching LOCK_TIMEOUT in WAIT_LOCK or FILTER -> if MAX_RETRY!=0 and retry_cnt_o==MAX_RETRY, go to FAULT; otherwise increment retry_cnt_o (saturating) and go to PLL_RST.
  - RELEASE: first cycle is T0. dom_rst_n_o[i] rises at T0+STAGE_GAP*(i+1) and stays high. ready_o rises in the same cycle as the last domain; state -> RUN.
  - RUN: holding state; ready_o=1.
  - FAULT: pll_rst_o=1, dom_rst_n_o=0, ready_o=0, fault_o=1. Stays until restart_i or rst_n.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - Next edge: dom_rst_n_o all 0, ready_o=0, lock_loss_o=1 for one cycle, retry_cnt_o=0, state -> PLL_RST.
- restart_i (any state):
  - Next edge: state -> PLL_RST, retry_cnt_o=0, fault_o=0, dom_rst_n_o=0, ready_o=0, pll_rst_o=1.
- Priority within one cycle: restart_i > lock loss > timeout > normal transition. A lock loss that coincides with restart_i does not pulse lock_loss_o.
- Domain resets only ever rise in order (bit i never before bit i-1) and always fall together.
- ready_o=1 implies dom_rst_n_o is all ones and pll_rst_o=0.

Test Plan:
Bench parameters for all scenarios: NUM_DOM=3, PLL_RST_CYCLES=4, LOCK_FILT=4, LOCK_TIMEOUT=32, STAGE_GAP=2, MAX_RETRY=2.
1. Normal bring-up: release rst_n; lock_i rises 10 cycles after pll_rst_o falls and stays high -> pll_rst_o high for 4 cycles; RELEASE entered 3+4 edges after the lock rise; dom_rst_n_o goes 001/011/111 at T0+2/+4/+6; ready_o=1 at T0+6; retry_cnt_o=0.
2. Glitchy lock: lock_i high 3 cycles, low 2 cycles, then steady high -> no release until 4 consecutive lock_s highs; timer not reset by the glitch.
3. No lock: lock_i held 0 -> pll_rst_o re-pulses every 4+32 cycles; retry_cnt_o steps 1, 2; third timeout gives fault_o=1 and pll_rst_o held 1 indefinitely.
4. Lock loss in RUN: drop lock_i -> on the 3rd edge dom_rst_n_o=000, ready_o=0, lock_loss_o high one cycle; pll_rst_o high 4 cycles; full re-sequence on relock.
5. Restart: restart_i in FAULT -> fault_o=0, retry_cnt_o=0, normal bring-up follows. restart_i coincident with lock loss in RUN -> lock_loss_o stays 0.
6. Async reset mid-RELEASE: assert rst_n after dom bit 0 released -> all outputs return to reset values immediately, without waiting for a clk edge.
